screen_sample_ram: RTL and testbench

SCREEN_SAMPLE_RAM -- requirements
Module: screen_sample_ram

---
 rtl/screen_sample_ram.sv | 181 ++++++++++++++++++
 tb/tb_screen_sample_ram.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_sample_ram.sv
// rtl/screen_sample_ram.sv - single-port sample RAM shared by a capture stream and an Avalon-MM slave
module screen_sample_ram #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 25000,
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 1,
  parameter int CIRCULAR     = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic                avs_chipselect,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  input  logic                cap_arm,
  input  logic                cap_stop,
  input  logic                cap_valid,
  input  logic [DATA_W-1:0]   cap_data,
  output logic                cap_ready,
  output logic                cap_done,
  output logic [ADDR_W-1:0]   cap_ptr,
  output logic                cap_wrapped
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cap_ptr_q, cap_ptr_d;
  logic                wrapped_q, wrapped_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                cap_xfer;
  logic                avs_req;
  logic                avs_in_range;
  logic                wr_acc;
  logic                rd_acc;

  logic                ram_we;
  logic [IDX_W-1:0]    ram_widx;
  logic [DATA_W-1:0]   ram_wdata;
  logic [BYTES-1:0]    ram_be;

  logic                rd_v1_q;
  logic [DATA_W-1:0]   rd_d1_q;

  // The capture stream owns the RAM whenever it moves a sample; Avalon stalls for that cycle.
  assign cap_ready       = (state_q == ST_FILL);
  assign cap_xfer        = cap_valid & cap_ready;
  assign avs_req         = avs_chipselect & (avs_read | avs_write);
  assign avs_waitrequest = avs_req & cap_xfer;
  assign avs_in_range    = ({1'b0, avs_address} < DEPTH_EXT);
  assign wr_acc          = avs_chipselect & avs_write & ~avs_waitrequest;
  assign rd_acc          = avs_chipselect & avs_read & ~avs_write & ~avs_waitrequest;

  assign cap_done    = (state_q == ST_DONE);
  assign cap_ptr     = cap_ptr_q;
  assign cap_wrapped = wrapped_q;

  // Capture FSM state, pointer and wrap flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cap_ptr_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_ptr_q <= cap_ptr_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Next capture state: arm restarts from any state, otherwise advance on each accepted sample.
  always_comb begin
    state_d   = state_q;
    cap_ptr_d = cap_ptr_q;
    wrapped_d = wrapped_q;
    if (cap_arm) begin
      state_d   = ST_FILL;
      cap_ptr_d = '0;
      wrapped_d = 1'b0;
    end else if (state_q == ST_FILL) begin
      if (cap_xfer) begin
        if (cap_ptr_q == LAST_PTR) begin
          if (CIRCULAR != 0) begin
            cap_ptr_d = '0;
            wrapped_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cap_ptr_d = cap_ptr_q + ADDR_W'(1);
        end
      end
      if ((CIRCULAR != 0) && cap_stop) begin
        state_d = ST_DONE;
      end
    end
  end

  // Write-port mux: a capture sample writes every lane; Avalon writes only in range.
  always_comb begin
    ram_we    = 1'b0;
    ram_widx  = cap_ptr_q[IDX_W-1:0];
    ram_wdata = cap_data;
    ram_be    = '1;
    if (cap_xfer) begin
      ram_we = 1'b1;
    end else if (wr_acc && avs_in_range) begin
      ram_we    = 1'b1;
      ram_widx  = avs_address[IDX_W-1:0];
      ram_wdata = avs_writedata;
      ram_be    = avs_byteenable;
    end
  end

  // RAM storage with per-byte write enables; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (ram_be[b]) begin
          mem[ram_widx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  // First read stage; sampling mem here sees pre-write data, giving read-before-write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
    end else begin
      rd_v1_q <= rd_acc;
      if (rd_acc) begin
        rd_d1_q <= avs_in_range ? mem[avs_address[IDX_W-1:0]] : '0;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                rd_v2_q;
      logic [DATA_W-1:0]   rd_d2_q;

      // Optional second read stage, keeps the pipeline fully back-to-back.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_v2_q <= 1'b0;
          rd_d2_q <= '0;
        end else begin
          rd_v2_q <= rd_v1_q;
          if (rd_v1_q) begin
            rd_d2_q <= rd_d1_q;
          end
        end
      end

      assign avs_readdatavalid = rd_v2_q;
      assign avs_readdata      = rd_d2_q;
    end else begin : g_lat1
      assign avs_readdatavalid = rd_v1_q;
      assign avs_readdata      = rd_d1_q;
    end
  endgenerate

endmodule

// File: tb/tb_screen_sample_ram.sv
// tb/tb_screen_sample_ram.sv - self-checking bench: one-shot/latency-1 and circular/latency-2 instances
module tb_screen_sample_ram;

  localparam int DEP = 8;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] avs_address = '0;
  logic [3:0]    avs_byteenable = '0;
  logic          avs_chipselect = 1'b0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          cap_arm = 1'b0;
  logic          cap_stop = 1'b0;
  logic          cap_valid = 1'b0;
  logic [31:0]   cap_data = '0;

  logic          wait0, rv0, ready0, done0, wrap0;
  logic [31:0]   rdata0;
  logic [AW-1:0] ptr0;
  logic          wait1, rv1, ready1, done1, wrap1;
  logic [31:0]   rdata1;
  logic [AW-1:0] ptr1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  screen_sample_ram #(.DATA_W(32), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(1), .CIRCULAR(0)) u0 (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(wait0), .avs_readdata(rdata0),
    .avs_readdatavalid(rv0), .cap_arm(cap_arm), .cap_stop(cap_stop), .cap_valid(cap_valid),
    .cap_data(cap_data), .cap_ready(ready0), .cap_done(done0), .cap_ptr(ptr0), .cap_wrapped(wrap0));

  screen_sample_ram #(.DATA_W(32), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(2), .CIRCULAR(1)) u1 (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(wait1), .avs_readdata(rdata1),
    .avs_readdatavalid(rv1), .cap_arm(cap_arm), .cap_stop(cap_stop), .cap_valid(cap_valid),
    .cap_data(cap_data), .cap_ready(ready1), .cap_done(done1), .cap_ptr(ptr1), .cap_wrapped(wrap1));

  // Reference model, one entry per instance: instance 0 is one-shot, instance 1 circular.
  logic [31:0] m_mem   [2][DEP];
  bit          m_known [2][DEP];
  bit          m_fill  [2];
  bit          m_done  [2];
  bit          m_wrap  [2];
  int          m_ptr   [2];
  bit          s_v     [2][4];
  bit          s_k     [2][4];
  logic [31:0] s_d     [2][4];

  function automatic int lat_of(input int i);
    return i + 1;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s u%0d: got 0x%0h expected 0x%0h", name, inst, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fill[i] = 0; m_done[i] = 0; m_wrap[i] = 0; m_ptr[i] = 0;
      for (int s = 0; s < 4; s++) s_v[i][s] = 0;
      for (int w = 0; w < DEP; w++) m_known[i][w] = 0;
    end
  endtask

  task automatic model_edge(input int i);
    bit xfer, stall, wacc, racc;
    int a, slot;
    a     = int'(avs_address);
    xfer  = m_fill[i] && cap_valid;
    stall = avs_chipselect && (avs_read || avs_write) && xfer;
    wacc  = avs_chipselect && avs_write && !stall;
    racc  = avs_chipselect && avs_read && !avs_write && !stall;
    if (racc) begin
      slot = (cyc + lat_of(i) - 1) % 4;
      s_v[i][slot] = 1;
      if (a < DEP) begin
        s_k[i][slot] = m_known[i][a];
        s_d[i][slot] = m_mem[i][a];
      end else begin
        s_k[i][slot] = 1;
        s_d[i][slot] = 32'h0;
      end
    end
    if (xfer) begin
      m_mem[i][m_ptr[i]]   = cap_data;
      m_known[i][m_ptr[i]] = 1;
    end else if (wacc && a < DEP) begin
      for (int b = 0; b < 4; b++)
        if (avs_byteenable[b]) m_mem[i][a][8*b +: 8] = avs_writedata[8*b +: 8];
      if (avs_byteenable == 4'hF) m_known[i][a] = 1;
    end
    if (cap_arm) begin
      m_fill[i] = 1; m_done[i] = 0; m_ptr[i] = 0; m_wrap[i] = 0;
    end else if (m_fill[i]) begin
      if (xfer) begin
        if (m_ptr[i] == DEP - 1) begin
          if (i == 1) begin m_ptr[i] = 0; m_wrap[i] = 1; end
          else begin m_fill[i] = 0; m_done[i] = 1; end
        end else begin
          m_ptr[i] = m_ptr[i] + 1;
        end
      end
      if (i == 1 && cap_stop) begin m_fill[i] = 0; m_done[i] = 1; end
    end
  endtask

  task automatic compare_inst(input int i, input logic wt, input logic [31:0] rd, input logic rv,
                              input logic rdy, input logic dn, input logic [AW-1:0] pt, input logic wp);
    int slot;
    slot = cyc % 4;
    check("cap_ready", i, rdy, m_fill[i]);
    check("cap_done", i, dn, m_done[i]);
    check("cap_ptr", i, pt, m_ptr[i]);
    check("cap_wrapped", i, wp, m_wrap[i]);
    check("waitrequest", i, wt, avs_chipselect && (avs_read || avs_write) && cap_valid && m_fill[i]);
    check("readdatavalid", i, rv, s_v[i][slot]);
    if (s_v[i][slot] && s_k[i][slot]) check("readdata", i, rd, s_d[i][slot]);
    if (!reset_n) check("readdata_in_reset", i, rd, 32'h0);
    s_v[i][slot] = 0;
  endtask

  // Advance the model on every rising edge, then compare just after the edge.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) model_reset();
    else begin model_edge(0); model_edge(1); end
    #1;
    compare_inst(0, wait0, rdata0, rv0, ready0, done0, ptr0, wrap0);
    compare_inst(1, wait1, rdata1, rv1, ready1, done1, ptr1, wrap1);
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic idle_bus();
    avs_chipselect = 0; avs_read = 0; avs_write = 0;
  endtask

  task automatic avs_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avs_chipselect = 1; avs_write = 1; avs_read = 0;
    avs_address = AW'(a); avs_writedata = d; avs_byteenable = be;
    @(negedge clk);
    idle_bus();
  endtask

  // Called with a read already driven that will be accepted at the next edge.
  task automatic collect(output logic [31:0] d0, output logic [31:0] d1, output int l0, output int l1);
    d0 = '0; d1 = '0; l0 = -1; l1 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) idle_bus();
      if (rv0 && l0 < 0) begin l0 = k; d0 = rdata0; end
      if (rv1 && l1 < 0) begin l1 = k; d1 = rdata1; end
    end
  endtask

  task automatic avs_rd(input int a, output logic [31:0] d0, output logic [31:0] d1, output int l0, output int l1);
    @(negedge clk);
    avs_chipselect = 1; avs_read = 1; avs_write = 0; avs_address = AW'(a);
    collect(d0, d1, l0, l1);
  endtask

  task automatic arm();
    @(negedge clk); cap_arm = 1;
    @(negedge clk); cap_arm = 0;
  endtask

  task automatic stream(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); cap_valid = 1; cap_data = 32'(base + k);
    end
    @(negedge clk); cap_valid = 0;
  endtask

  task automatic read_pair(input int a, input logic [31:0] e0, input logic [31:0] e1, input string tag);
    logic [31:0] d0, d1;
    int l0, l1;
    avs_rd(a, d0, d1, l0, l1);
    check({tag, "_data"}, 0, d0, e0);
    check({tag, "_data"}, 1, d1, e1);
    check({tag, "_lat"}, 0, l0, 1);
    check({tag, "_lat"}, 1, l1, 2);
  endtask

  initial begin
    logic [31:0] d0, d1;
    int l0, l1, nv;

    repeat (3) @(negedge clk);
    check("lit_rst_ptr", 0, ptr0, 0);       check("lit_rst_ptr", 1, ptr1, 0);
    check("lit_rst_ready", 0, ready0, 0);   check("lit_rst_ready", 1, ready1, 0);
    check("lit_rst_done", 0, done0, 0);     check("lit_rst_wrap", 1, wrap1, 0);
    check("lit_rst_rvalid", 0, rv0, 0);     check("lit_rst_rvalid", 1, rv1, 0);
    check("lit_rst_rdata", 0, rdata0, 0);   check("lit_rst_rdata", 1, rdata1, 0);
    reset_n = 1;

    // Byte-lane write over zeroed word.
    avs_wr(3, 32'h0, 4'hF);
    avs_wr(3, 32'hA5A5A5A5, 4'b0101);
    read_pair(3, 32'h00A500A5, 32'h00A500A5, "lit_be");

    // Read and write together is a write with no read beat.
    @(negedge clk);
    avs_chipselect = 1; avs_read = 1; avs_write = 1; avs_address = 4'd5;
    avs_writedata = 32'h55; avs_byteenable = 4'hF;
    nv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle_bus();
      if (rv0 || rv1) nv++;
    end
    check("lit_rw_beats", 0, nv, 0);
    read_pair(5, 32'h55, 32'h55, "lit_rw");

    // One-shot stops after 8; circular wraps and keeps going.
    arm();
    stream(10, 1);
    check("lit_os_done", 0, done0, 1);  check("lit_os_ready", 0, ready0, 0);
    check("lit_os_ptr", 0, ptr0, 7);    check("lit_circ_ptr", 1, ptr1, 2);
    check("lit_circ_wrap", 1, wrap1, 1);
    for (int w = 0; w < DEP; w++)
      read_pair(w, 32'(w + 1), (w < 2) ? 32'(9 + w) : 32'(w + 1), "lit_fill10");

    // Eleven samples then stop.
    arm();
    stream(11, 1);
    @(negedge clk); cap_stop = 1;
    @(negedge clk); cap_stop = 0;
    check("lit_stop_done", 1, done1, 1);  check("lit_stop_ready", 1, ready1, 0);
    check("lit_stop_wrap", 1, wrap1, 1);  check("lit_stop_ptr", 1, ptr1, 3);
    check("lit_stop_ptr", 0, ptr0, 7);
    for (int w = 0; w < DEP; w++)
      read_pair(w, 32'(w + 1), (w < 3) ? 32'(9 + w) : 32'(w + 1), "lit_fill11");

    // Out-of-range read returns zero; out-of-range write must not alias word 0.
    read_pair(DEP + 1, 32'h0, 32'h0, "lit_oor_rd");
    avs_wr(DEP, 32'hDEADBEEF, 4'hF);
    read_pair(0, 32'd1, 32'd9, "lit_oor_wr");

    // Read held while capture streams.
    arm();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cap_valid = 1; cap_data = 32'(100 + k);
      avs_chipselect = 1; avs_read = 1; avs_write = 0; avs_address = 4'd6;
      #1;
      check("lit_hold_wait", 0, wait0, 1);
      check("lit_hold_wait", 1, wait1, 1);
    end
    @(negedge clk); cap_valid = 0;
    collect(d0, d1, l0, l1);
    check("lit_hold_data", 0, d0, 7);  check("lit_hold_data", 1, d1, 7);
    check("lit_hold_lat", 0, l0, 1);   check("lit_hold_lat", 1, l1, 2);
    check("lit_hold_ptr", 0, ptr0, 3); check("lit_hold_ptr", 1, ptr1, 3);
    @(negedge clk); cap_stop = 1;
    @(negedge clk); cap_stop = 0;
    check("lit_stop_ignored", 0, ready0, 1);
    check("lit_stop_circ", 1, done1, 1);

    // Reset mid-fill with reads outstanding.
    arm();
    stream(2, 200);
    @(negedge clk);
    avs_chipselect = 1; avs_read = 1; avs_write = 0; avs_address = 4'd0;
    @(negedge clk);
    avs_address = 4'd1;
    #2;
    reset_n = 0;
    idle_bus();
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rv0 || rv1) nv++;
    end
    check("lit_mid_rst_beats", 0, nv, 0);
    check("lit_mid_rst_ptr", 0, ptr0, 0);    check("lit_mid_rst_ptr", 1, ptr1, 0);
    check("lit_mid_rst_ready", 0, ready0, 0); check("lit_mid_rst_ready", 1, ready1, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    check("lit_post_rst_done", 0, done0, 0);  check("lit_post_rst_ready", 1, ready1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
